// File: rtl/clkx_bus_arb.sv
// Source-domain round-robin arbiter in front of one clkx_bus crossing.
// Each issue is followed by a fixed hold-off, so updates never outrun the crossing.
module clkx_bus_arb #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GAP   = 12
) (
   input  logic                                    clk_src,
   input  logic                                    rst_clk_src_n,
   input  logic [NREQ-1:0]                         req_src,
   input  logic [NREQ*WIDTH-1:0]                   data_src,
   output logic [NREQ-1:0]                         ack_src,
   output logic [WIDTH-1:0]                        bus_src,
   output logic                                    bus_new_src,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] bus_id_src,
   output logic                                    busy_src
);

   localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CNT_W = (GAP > 2) ? $clog2(GAP) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [NREQ-1:0]  ack_nxt;
   logic [WIDTH-1:0] bus_nxt;
   logic             bus_new_nxt;
   logic [ID_W-1:0]  bus_id_nxt;
   logic             busy_nxt;

   logic             found;
   logic [ID_W-1:0]  win;
   logic [WIDTH-1:0] win_data;

   // Round-robin search starting at rr_ptr, wrapping at NREQ (not at 2**ID_W).
   always_comb begin : p_pick
      int unsigned idx;
      found    = 1'b0;
      win      = '0;
      win_data = '0;
      idx      = 0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         idx = 32'(rr_ptr) + j;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_src[ID_W'(idx)]) begin
            found    = 1'b1;
            win      = ID_W'(idx);
            win_data = data_src[idx*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state and registered-output values.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rr_ptr_nxt  = rr_ptr;
      ack_nxt     = '0;
      bus_nxt     = bus_src;
      bus_new_nxt = 1'b0;
      bus_id_nxt  = bus_id_src;
      busy_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_nxt   = ST_HOLD;
               cnt_nxt     = CNT_LOAD;
               rr_ptr_nxt  = (win == LAST_ID) ? '0 : win + ID_W'(1);
               ack_nxt     = NREQ'(1) << win;
               bus_nxt     = win_data;
               bus_new_nxt = 1'b1;
               bus_id_nxt  = win;
               busy_nxt    = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt == CNT_ONE) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt  = cnt - CNT_ONE;
               busy_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_src or negedge rst_clk_src_n) begin
      if (!rst_clk_src_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rr_ptr      <= '0;
         ack_src     <= '0;
         bus_src     <= '0;
         bus_new_src <= 1'b0;
         bus_id_src  <= '0;
         busy_src    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         rr_ptr      <= rr_ptr_nxt;
         ack_src     <= ack_nxt;
         bus_src     <= bus_nxt;
         bus_new_src <= bus_new_nxt;
         bus_id_src  <= bus_id_nxt;
         busy_src    <= busy_nxt;
      end
   end

endmodule
